// File: rtl/fifo_widthconv_sc.sv
// fifo_widthconv_sc
//   Single-clock width-converting FIFO. Wide input words (RATIO x OUT_WIDTH
//   bits) are stored in a simple dual-port RAM. The read side is
//   first-word fall-through and presents them one OUT_WIDTH unit at a time.
//
// Parameters
//   OUT_WIDTH        output unit width in bits
//   RATIO            output units per input word (1, 2, 4 or 8)
//   DEPTH_LOG2       RAM depth is 2**DEPTH_LOG2 input words (>= 1)
//   PROG_FULL_THRESH prog_full asserts at or above this many stored words
//   MSB_FIRST        1: most-significant unit first, 0: least-significant first
//
// Ports
//   clk, rst_n       single clock, synchronous active-low reset
//   din, wr_en       write side; a word is taken when wr_en=1 and full=0
//   full             RAM holds DEPTH words
//   almost_full      RAM holds >= DEPTH-1 words
//   prog_full        RAM holds >= PROG_FULL_THRESH words
//   mem_count        words in RAM (the word in the output stage is not counted)
//   dout, empty      read side; dout is valid whenever empty=0
//   rd_en            consumes the current unit when empty=0
//
// Handshake: this block uses a FIFO-style valid/ready contract on both sides.
//   On the write side, wr_en is "valid" and ~full is "ready". A word transfers
//   on a rising edge where both are high. wr_en while full is dropped.
//   On the read side, ~empty is "valid" and rd_en is "ready". A unit transfers
//   on a rising edge where both are high. rd_en while empty is ignored.
//   dout is stable from the edge that makes it valid until the edge that
//   consumes it.

module fifo_widthconv_sc #(
    parameter int OUT_WIDTH        = 8,
    parameter int RATIO            = 2,
    parameter int DEPTH_LOG2       = 10,
    parameter int PROG_FULL_THRESH = 512,
    parameter int MSB_FIRST        = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [OUT_WIDTH*RATIO-1:0]    din,
    input  logic                          wr_en,
    output logic                          full,
    output logic                          almost_full,
    output logic                          prog_full,
    output logic [DEPTH_LOG2:0]           mem_count,
    input  logic                          rd_en,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          empty
);

    localparam int IN_WIDTH = OUT_WIDTH * RATIO;
    localparam int DEPTH    = 2 ** DEPTH_LOG2;
    // sub_idx needs at least one bit even when RATIO=1. In that case it stays 0.
    localparam int SUB_W    = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [SUB_W-1:0]      LAST_SUB = SUB_W'(RATIO - 1);
    localparam logic [DEPTH_LOG2:0]   FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   AF_CNT   = (DEPTH_LOG2 + 1)'(DEPTH - 1);
    localparam logic [DEPTH_LOG2:0]   PF_CNT   = (DEPTH_LOG2 + 1)'(PROG_FULL_THRESH);

    logic [IN_WIDTH-1:0]   mem [DEPTH];

    logic [DEPTH_LOG2:0]   wr_ptr;
    logic [DEPTH_LOG2:0]   rd_ptr;
    logic [DEPTH_LOG2:0]   occ;
    logic [DEPTH_LOG2:0]   occ_next;

    logic [IN_WIDTH-1:0]   hold_word;
    logic                  hold_valid;
    logic [SUB_W-1:0]      sub_idx;
    logic [SUB_W-1:0]      slice_idx;

    logic                  wr_accept;
    logic                  consume;
    logic                  last_unit;
    logic                  release_word;
    logic                  fetch;

    // The pointers carry one extra wrap bit, so the difference is the exact
    // occupancy 0..DEPTH with no separate counter.
    assign occ          = wr_ptr - rd_ptr;

    // full is registered from the next-state occupancy, so it equals
    // (occ == DEPTH) in every cycle. Using it here means a write in the same
    // cycle as the fetch that frees a slot is still rejected.
    assign wr_accept    = wr_en & ~full;
    assign consume      = rd_en & hold_valid;
    assign last_unit    = (sub_idx == LAST_SUB);
    assign release_word = consume & last_unit;

    // A fetch needs the RAM non-empty before the edge. The read address can
    // therefore never be the slot being written in the same cycle.
    assign fetch        = (occ != '0) & (~hold_valid | release_word);

    always_comb begin
        occ_next = occ;
        if (wr_accept && !fetch) begin
            occ_next = occ + 1'b1;
        end else if (!wr_accept && fetch) begin
            occ_next = occ - 1'b1;
        end
    end

    // RAM write port. The array is not reset, which keeps it inferable as
    // block RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_accept) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            hold_word   <= '0;
            hold_valid  <= 1'b0;
            sub_idx     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            prog_full   <= 1'b0;
            mem_count   <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end

            // Fetch overrides release, so the next word follows the last unit
            // of the current one with no bubble.
            if (fetch) begin
                hold_word  <= mem[rd_ptr[DEPTH_LOG2-1:0]];
                rd_ptr     <= rd_ptr + 1'b1;
                hold_valid <= 1'b1;
            end else if (release_word) begin
                hold_valid <= 1'b0;
            end

            if (consume) begin
                sub_idx <= last_unit ? '0 : sub_idx + 1'b1;
            end

            full        <= (occ_next == FULL_CNT);
            almost_full <= (occ_next >= AF_CNT);
            prog_full   <= (occ_next >= PF_CNT);
            mem_count   <= occ_next;
        end
    end

    // sub_idx counts units in emission order. Map it to the physical slice.
    always_comb begin
        if (MSB_FIRST != 0) begin
            slice_idx = LAST_SUB - sub_idx;
        end else begin
            slice_idx = sub_idx;
        end
    end

    assign dout  = hold_word[slice_idx*OUT_WIDTH +: OUT_WIDTH];
    assign empty = ~hold_valid;

endmodule

// File: tb/tb_fifo_widthconv_sc.sv
module tb_fifo_widthconv_sc;

    localparam int DEPTH = 1024;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters (RATIO=2, MSB first)
    logic [15:0] din_a = '0;
    logic        wr_en_a = 1'b0;
    logic        rd_en_a = 1'b0;
    logic        full_a, af_a, pf_a, empty_a;
    logic [10:0] cnt_a;
    logic [7:0]  dout_a;

    // DUT B: RATIO=4, LSB first
    logic [31:0] din_b = '0;
    logic        wr_en_b = 1'b0;
    logic        rd_en_b = 1'b0;
    logic        full_b, af_b, pf_b, empty_b;
    logic [10:0] cnt_b;
    logic [7:0]  dout_b;

    fifo_widthconv_sc u_dut_a (
        .clk(clk), .rst_n(rst_n), .din(din_a), .wr_en(wr_en_a),
        .full(full_a), .almost_full(af_a), .prog_full(pf_a), .mem_count(cnt_a),
        .rd_en(rd_en_a), .dout(dout_a), .empty(empty_a)
    );

    fifo_widthconv_sc #(.RATIO(4), .MSB_FIRST(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .din(din_b), .wr_en(wr_en_b),
        .full(full_b), .almost_full(af_b), .prog_full(pf_b), .mem_count(cnt_b),
        .rd_en(rd_en_b), .dout(dout_b), .empty(empty_b)
    );

    int checks = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Words waiting in memory, and the units of the word in the output stage
    // in emission order.
    logic [15:0] mem_a[$];
    logic [7:0]  exp_q_a[$];
    logic [31:0] mem_b[$];
    logic [7:0]  exp_q_b[$];

    function automatic logic [14:0] exp_status_a();
        int n = mem_a.size();
        return {exp_q_a.size() == 0, n == DEPTH, n >= DEPTH - 1, n >= 512, 11'(n)};
    endfunction

    function automatic logic [14:0] exp_status_b();
        int n = mem_b.size();
        return {exp_q_b.size() == 0, n == DEPTH, n >= DEPTH - 1, n >= 512, 11'(n)};
    endfunction

    // One clock edge. The model sees the same inputs the DUTs sample.
    task automatic tick();
        logic [15:0] wa;
        logic [31:0] wb;
        bit          acc;
        @(posedge clk);
        if (!rst_n) begin
            mem_a.delete(); exp_q_a.delete();
            mem_b.delete(); exp_q_b.delete();
        end else begin
            if (rd_en_a && exp_q_a.size() > 0) void'(exp_q_a.pop_front());
            acc = wr_en_a && (mem_a.size() < DEPTH);
            if (exp_q_a.size() == 0 && mem_a.size() > 0) begin
                wa = mem_a.pop_front();
                for (int k = 0; k < 2; k++) exp_q_a.push_back(wa[8*(1-k) +: 8]);
            end
            if (acc) mem_a.push_back(din_a);

            if (rd_en_b && exp_q_b.size() > 0) void'(exp_q_b.pop_front());
            acc = wr_en_b && (mem_b.size() < DEPTH);
            if (exp_q_b.size() == 0 && mem_b.size() > 0) begin
                wb = mem_b.pop_front();
                for (int k = 0; k < 4; k++) exp_q_b.push_back(wb[8*k +: 8]);
            end
            if (acc) mem_b.push_back(din_b);
        end
        #1;
    endtask

    function automatic logic [15:0] rand_word_a();
        // Bytes stay below 8'hAD so the DE/AD marker can never appear legitimately.
        return {8'($urandom_range(0, 8'hAC)), 8'($urandom_range(0, 8'hAC))};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wr_en_a = 1'($urandom_range(0, 1)); rd_en_a = 1'($urandom_range(0, 1));
            wr_en_b = 1'($urandom_range(0, 1)); rd_en_b = 1'($urandom_range(0, 1));
            din_a = 16'($urandom); din_b = $urandom;
            tick();
        end
        checks++;
        if ({empty_a, full_a, af_a, pf_a, cnt_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL reset_status_a: got %h expected %h", {empty_a, full_a, af_a, pf_a, cnt_a}, {1'b1, 14'd0});
        end
        checks++;
        if (dout_a !== 8'h00) begin
            failures++; $display("FAIL reset_dout_a: got %h expected 00", dout_a);
        end
        checks++;
        if ({empty_b, full_b, af_b, pf_b, cnt_b} !== {1'b1, 1'b0, 1'b0, 1'b0, 11'd0}) begin
            failures++;
            $display("FAIL reset_status_b: got %h expected %h", {empty_b, full_b, af_b, pf_b, cnt_b}, {1'b1, 14'd0});
        end
        checks++;
        if (dout_b !== 8'h00) begin
            failures++; $display("FAIL reset_dout_b: got %h expected 00", dout_b);
        end
        wr_en_a = 0; rd_en_a = 0; wr_en_b = 0; rd_en_b = 0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        wr_en_a = 1'b1; din_a = 16'hA1B2;
        tick();
        wr_en_a = 1'b0;
        checks++;
        if (empty_a !== 1'b1) begin
            failures++; $display("FAIL single_latency: empty got %b expected 1", empty_a);
        end
        tick();
        checks++;
        if (empty_a !== 1'b0 || dout_a !== 8'hA1) begin
            failures++; $display("FAIL single_first: empty=%b dout=%h expected empty=0 dout=a1", empty_a, dout_a);
        end
        rd_en_a = 1'b1;
        tick();
        checks++;
        if (empty_a !== 1'b0 || dout_a !== 8'hB2) begin
            failures++; $display("FAIL single_second: empty=%b dout=%h expected empty=0 dout=b2", empty_a, dout_a);
        end
        tick();
        rd_en_a = 1'b0;
        checks++;
        if ({empty_a, full_a, af_a, pf_a, cnt_a} !== exp_status_a()) begin
            failures++;
            $display("FAIL single_drained: got %h expected %h", {empty_a, full_a, af_a, pf_a, cnt_a}, exp_status_a());
        end
    endtask

    task automatic test_stream();
        int wi = 0;
        int n_out = 0;
        logic [15:0] ew;
        logic [7:0]  eu;
        for (int cyc = 0; cyc < 4000 && n_out < 2048; cyc++) begin
            wr_en_a = (wi < 1024);
            din_a   = 16'(wi);
            rd_en_a = 1'b1;
            if (!empty_a) begin
                ew = 16'(n_out / 2);
                eu = (n_out % 2 == 0) ? ew[15:8] : ew[7:0];
                checks++;
                if (dout_a !== eu) begin
                    failures++; $display("FAIL stream_data[%0d]: got %h expected %h", n_out, dout_a, eu);
                end
                n_out++;
            end else begin
                checks++;
                if (n_out != 0) begin
                    failures++; $display("FAIL stream_bubble: empty at unit %0d expected 0 bubbles", n_out);
                end
            end
            tick();
            if (wr_en_a) wi++;
            checks++;
            if ({empty_a, full_a, af_a, pf_a, cnt_a} !== exp_status_a()) begin
                failures++;
                $display("FAIL stream_status: got %h expected %h", {empty_a, full_a, af_a, pf_a, cnt_a}, exp_status_a());
            end
        end
        wr_en_a = 1'b0; rd_en_a = 1'b0;
        checks++;
        if (n_out != 2048) begin
            failures++; $display("FAIL stream_count: got %0d units expected 2048", n_out);
        end
    endtask

    task automatic test_fill();
        int n = 0;
        while (!full_a && n < 1100) begin
            wr_en_a = 1'b1; din_a = rand_word_a();
            tick();
            n++;
            checks++;
            if ({empty_a, full_a, af_a, pf_a, cnt_a} !== exp_status_a()) begin
                failures++;
                $display("FAIL fill_status[%0d]: got %h expected %h", n, {empty_a, full_a, af_a, pf_a, cnt_a}, exp_status_a());
            end
        end
        checks++;
        if (full_a !== 1'b1 || cnt_a !== 11'd1024) begin
            failures++; $display("FAIL fill_reach_full: full=%b count=%0d expected full=1 count=1024", full_a, cnt_a);
        end
        // Overflow attempt while full.
        wr_en_a = 1'b1; din_a = 16'hDEAD;
        tick();
        wr_en_a = 1'b0;
        checks++;
        if (full_a !== 1'b1 || cnt_a !== 11'd1024) begin
            failures++; $display("FAIL fill_overflow: full=%b count=%0d expected full=1 count=1024", full_a, cnt_a);
        end
    endtask

    task automatic test_full_boundary();
        wr_en_a = 1'b1; din_a = 16'h5555; rd_en_a = 1'b1;
        tick();   // first unit consumed, no fetch, write rejected
        checks++;
        if (full_a !== 1'b1 || cnt_a !== 11'd1024) begin
            failures++; $display("FAIL boundary_first: full=%b count=%0d expected full=1 count=1024", full_a, cnt_a);
        end
        tick();   // last unit consumed, fetch, write still rejected
        rd_en_a = 1'b0;
        checks++;
        if (full_a !== 1'b0 || cnt_a !== 11'd1023) begin
            failures++; $display("FAIL boundary_fetch: full=%b count=%0d expected full=0 count=1023", full_a, cnt_a);
        end
        tick();   // write now accepted
        wr_en_a = 1'b0;
        checks++;
        if (full_a !== 1'b1 || cnt_a !== 11'd1024) begin
            failures++; $display("FAIL boundary_refill: full=%b count=%0d expected full=1 count=1024", full_a, cnt_a);
        end
        checks++;
        if ({empty_a, full_a, af_a, pf_a, cnt_a} !== exp_status_a()) begin
            failures++;
            $display("FAIL boundary_status: got %h expected %h", {empty_a, full_a, af_a, pf_a, cnt_a}, exp_status_a());
        end
    endtask

    task automatic test_drain();
        int n = 0;
        rd_en_a = 1'b1;
        for (int cyc = 0; cyc < 3000 && !empty_a; cyc++) begin
            checks++;
            if (dout_a !== exp_q_a[0] || dout_a === 8'hDE || dout_a === 8'hAD) begin
                failures++; $display("FAIL drain_data[%0d]: got %h expected %h", n, dout_a, exp_q_a[0]);
            end
            n++;
            tick();
        end
        rd_en_a = 1'b0;
        // One leftover word in the output stage plus 1024 stored words.
        checks++;
        if (n != 2050) begin
            failures++; $display("FAIL drain_count: got %0d units expected 2050", n);
        end
        checks++;
        if ({empty_a, full_a, af_a, pf_a, cnt_a} !== {1'b1, 14'd0}) begin
            failures++; $display("FAIL drain_status: got %h expected %h", {empty_a, full_a, af_a, pf_a, cnt_a}, {1'b1, 14'd0});
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            wr_en_a = ($urandom_range(0, 99) < 40);
            rd_en_a = ($urandom_range(0, 99) < 70);
            din_a   = 16'($urandom);
            if (!empty_a) begin
                checks++;
                if (dout_a !== exp_q_a[0]) begin
                    failures++; $display("FAIL random_data[%0d]: got %h expected %h", cyc, dout_a, exp_q_a[0]);
                end
            end
            tick();
            checks++;
            if ({empty_a, full_a, af_a, pf_a, cnt_a} !== exp_status_a()) begin
                failures++;
                $display("FAIL random_status[%0d]: got %h expected %h", cyc, {empty_a, full_a, af_a, pf_a, cnt_a}, exp_status_a());
            end
        end
        wr_en_a = 1'b0; rd_en_a = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [7:0] exp_units[4];
        for (int i = 0; i < 100; i++) begin
            wr_en_b = 1'b1; din_b = $urandom;
            tick();
        end
        wr_en_b = 1'b0;
        checks++;
        if ({empty_b, full_b, af_b, pf_b, cnt_b} !== exp_status_b()) begin
            failures++;
            $display("FAIL mid_fill_status: got %h expected %h", {empty_b, full_b, af_b, pf_b, cnt_b}, exp_status_b());
        end
        rd_en_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (dout_b !== exp_q_b[0]) begin
                failures++; $display("FAIL mid_read[%0d]: got %h expected %h", i, dout_b, exp_q_b[0]);
            end
            tick();
        end
        rd_en_b = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (empty_b !== 1'b1 || cnt_b !== 11'd0) begin
            failures++; $display("FAIL mid_reset: empty=%b count=%0d expected empty=1 count=0", empty_b, cnt_b);
        end
        wr_en_b = 1'b1; din_b = 32'h44332211;
        tick();
        wr_en_b = 1'b0;
        tick();
        exp_units = '{8'h11, 8'h22, 8'h33, 8'h44};
        rd_en_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (empty_b !== 1'b0 || dout_b !== exp_units[i]) begin
                failures++; $display("FAIL lsb_order[%0d]: empty=%b dout=%h expected empty=0 dout=%h", i, empty_b, dout_b, exp_units[i]);
            end
            tick();
        end
        rd_en_b = 1'b0;
        checks++;
        if ({empty_b, full_b, af_b, pf_b, cnt_b} !== {1'b1, 14'd0}) begin
            failures++; $display("FAIL lsb_final: got %h expected %h", {empty_b, full_b, af_b, pf_b, cnt_b}, {1'b1, 14'd0});
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_single();
        test_stream();
        test_fill();
        test_full_boundary();
        test_drain();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
